// File: rtl/usb_fs_tx.sv
// ---------------------------------------------------------------------------
// usb_fs_tx: full-speed (12 Mb/s) USB serial transmitter.
//
// Takes packet bytes over a valid/ready byte interface and drives the D+/D-
// pad values. Each packet is SYNC, then the NRZI-encoded, bit-stuffed payload
// sent LSB first, then EOP (SE0, SE0, J). The design runs from the 48 MHz
// clock, so each USB bit lasts CLKS_PER_BIT clocks. Every output is
// registered.
//
// Parameters:
//   CLKS_PER_BIT : clk48 cycles per USB bit period (must be >= 2)
//   STUFF_LEN    : run of consecutive 1 bits after which a 0 is stuffed
//
// Ports:
//   clk48       in   48 MHz system clock
//   rst_n       in   asynchronous active-low reset
//   tx_data     in   payload byte, sent LSB first
//   tx_valid    in   tx_data/tx_last valid; in IDLE this starts a packet
//   tx_last     in   the current byte is the final byte of the packet
//   tx_ready    out  one-clock load pulse; byte taken on tx_valid && tx_ready
//   usb_tx_dp   out  D+ drive value
//   usb_tx_dn   out  D- drive value
//   usb_tx_oe   out  pad output enable, high for the whole packet incl. EOP
//   tx_busy     out  high from packet start until the last EOP bit ends
//   tx_underrun out  one-clock pulse when a load cycle found tx_valid low
// ---------------------------------------------------------------------------
module usb_fs_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LEN    = 6
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_tx_dp,
  output logic       usb_tx_dn,
  output logic       usb_tx_oe,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_PRE  = PW'(CLKS_PER_BIT - 2);
  localparam logic [OW-1:0] ONES_MAX   = OW'(STUFF_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [1:0]    eop_cnt_q, eop_cnt_d;
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          oe_q, oe_d;
  logic          ready_q, ready_d;
  logic          underrun_q, underrun_d;
  logic          busy_q, busy_d;

  logic          advance;
  logic          stuff_pending;
  logic          load_window;
  logic          emit;
  logic          tx_bit;
  logic          enter_eop;

  // A new bit slot starts on the clock edge that ends the last phase of the
  // current slot. During SYNC/DATA, dp_q is the current J/K level, so it is
  // the NRZI reference for the next bit.
  assign advance       = (state_q != ST_IDLE) && (phase_q == PHASE_LAST);
  assign stuff_pending = (state_q == ST_DATA) && (ones_q == ONES_MAX);

  // The slot on the line is the final bit of SYNC or of a non-last byte, and
  // no stuff bit follows it. The next byte must be loaded at the end of this
  // slot. When a stuff bit is pending, the window moves to the stuff slot,
  // because bit_cnt holds its value through that slot.
  assign load_window = (bit_cnt_q == 3'd7) &&
                       ((state_q == ST_SYNC) ||
                        ((state_q == ST_DATA) && !stuff_pending && !last_q));

  // Next-state and output logic. Each branch only chooses what happens in the
  // next bit slot (emit a bit, load a byte, or enter EOP). The shared tails
  // below then apply the NRZI/stuffing update and the SE0 drive.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    ones_d     = ones_q;
    eop_cnt_d  = eop_cnt_q;
    dp_d       = dp_q;
    dn_d       = dn_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    underrun_d = 1'b0;
    emit       = 1'b0;
    tx_bit     = 1'b0;
    enter_eop  = 1'b0;

    if (state_q != ST_IDLE) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      // tx_ready is registered, so it is raised one clock ahead. This makes
      // it cover exactly the final clock of the load-window slot.
      ready_d = (phase_q == PHASE_PRE) && load_window;
    end

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (tx_valid) begin
          // First SYNC bit is a 0, so the line toggles J -> K at once.
          state_d   = ST_SYNC;
          busy_d    = 1'b1;
          oe_d      = 1'b1;
          bit_cnt_d = 3'd0;
          ones_d    = '0;
          emit      = 1'b1;
          tx_bit    = 1'b0;
        end
      end

      ST_SYNC: begin
        if (advance && !load_window) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          emit      = 1'b1;
          tx_bit    = (bit_cnt_q == 3'd6);
        end
      end

      ST_DATA: begin
        if (advance) begin
          if (stuff_pending) begin
            // The stuffed 0 occupies a slot without consuming a data bit.
            emit   = 1'b1;
            tx_bit = 1'b0;
          end else if ((bit_cnt_q == 3'd7) && last_q) begin
            enter_eop = 1'b1;
          end else if (!load_window) begin
            // shift_q[0] is the bit already sent. A stuff slot leaves shift_q
            // unchanged, so shift_q[1] is always the next data bit.
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            emit      = 1'b1;
            tx_bit    = shift_q[1];
          end
        end
      end

      ST_EOP: begin
        if (advance) begin
          if (eop_cnt_q == 2'd2) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            ones_d    = '0;
            dp_d      = 1'b1;
            dn_d      = 1'b0;
            eop_cnt_d = 2'd0;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
            if (eop_cnt_q == 2'd1) begin
              dp_d = 1'b1;
              dn_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Load cycle: take the offered byte, or abort into EOP on underrun.
    if (advance && load_window) begin
      if (tx_valid) begin
        state_d   = ST_DATA;
        shift_d   = tx_data;
        last_d    = tx_last;
        bit_cnt_d = 3'd0;
        emit      = 1'b1;
        tx_bit    = tx_data[0];
      end else begin
        underrun_d = 1'b1;
        enter_eop  = 1'b1;
      end
    end

    if (enter_eop) begin
      state_d   = ST_EOP;
      eop_cnt_d = 2'd0;
      dp_d      = 1'b0;
      dn_d      = 1'b0;
    end

    // NRZI: a 1 holds the line, a 0 toggles J <-> K. The ones counter follows
    // every bit placed on the line, stuffed bits included.
    if (emit) begin
      dp_d   = tx_bit ? dp_q : ~dp_q;
      dn_d   = tx_bit ? dn_q : ~dn_q;
      ones_d = tx_bit ? (ones_q + OW'(1)) : '0;
    end
  end

  // State and output registers. Reset returns to idle J with the pads
  // released, and drops any packet in flight without sending EOP.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      last_q     <= 1'b0;
      ones_q     <= '0;
      eop_cnt_q  <= 2'd0;
      dp_q       <= 1'b1;
      dn_q       <= 1'b0;
      oe_q       <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      ones_q     <= ones_d;
      eop_cnt_q  <= eop_cnt_d;
      dp_q       <= dp_d;
      dn_q       <= dn_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready    = ready_q;
  assign usb_tx_dp   = dp_q;
  assign usb_tx_dn   = dn_q;
  assign usb_tx_oe   = oe_q;
  assign tx_busy     = busy_q;
  assign tx_underrun = underrun_q;

endmodule
